interrupt_arbiter: RTL and testbench

- Collects the 8 HardwareInterrupt lines, latches rising edges as pending, masks them, and picks one winner by fixed priority.
- Raises a request to the multicycle control FSM only at an instruction boundary, then hands the FSM the winner's ID and vector address.
- Holds off further requests until the handler returns (no nesting).
- Sits between the external interrupt pins and the control unit's InterruptIn/EPCWrite path.

---
 rtl/interrupt_arbiter_pkg.sv | 29 ++
 rtl/interrupt_arbiter_prio_enc.sv | 14 +
 rtl/interrupt_arbiter.sv | 135 +++++++++++++
 tb/tb_interrupt_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM states,
// line/ID widths, configuration selectors and the fixed-priority encoder function.
package interrupt_pkg;

    localparam int NUM_LINES = 8;
    localparam int ID_W      = $clog2(NUM_LINES);

    localparam logic CFG_SEL_MASK = 1'b0;
    localparam logic CFG_SEL_GEN  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Ascending scan so the last (highest) set index wins.
    function automatic logic [ID_W-1:0] prio_encode(input logic [NUM_LINES-1:0] eligible);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (eligible[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_arbiter_prio_enc.sv
// Combinational fixed-priority encoder: highest set eligible line wins,
// win_vld flags that at least one line is eligible.
module int_priority_encoder
    import interrupt_pkg::*;
(
    input  logic [NUM_LINES-1:0] eligible,
    output logic [ID_W-1:0]      win_id,
    output logic                 win_vld
);

    assign win_id  = prio_encode(eligible);
    assign win_vld = |eligible;

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: edge-latches hardware lines into Pending, masks them and
// requests the control FSM at instruction boundaries. Optional INT_SYNC_EN adds a 2-flop input synchronizer.
module interrupt_arbiter
    import interrupt_pkg::*;
#(
    parameter logic [15:0]          VECTOR_BASE  = 16'h0100,
    parameter int                   VECTOR_SHIFT = 4,
    parameter logic [NUM_LINES-1:0] RESET_MASK   = 8'hFF
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [NUM_LINES-1:0] HardwareInterrupt,
    input  logic                 InstrBoundary,
    input  logic                 IntAck,
    input  logic                 IntReturn,
    input  logic                 CfgWrite,
    input  logic                 CfgSel,
    input  logic [7:0]           CfgData,
    output logic                 IntRequest,
    output logic [ID_W-1:0]      IntId,
    output logic [15:0]          IntVector,
    output logic                 Busy,
    output logic [NUM_LINES-1:0] Pending,
    output logic [NUM_LINES-1:0] Mask,
    output logic                 GlobalEnable
);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [NUM_LINES-1:0]   pending_q, pending_d;
    logic [NUM_LINES-1:0]   mask_q, mask_d;
    logic                   gen_q, gen_d;
    logic [NUM_LINES-1:0]   hist_q, hist_d;
    logic [NUM_LINES-1:0]   line_s;
    logic [NUM_LINES-1:0]   rise;
    logic [NUM_LINES-1:0]   ack_clr;
    logic [NUM_LINES-1:0]   eligible;
    logic [ID_W-1:0]        win_id;
    logic                   win_vld;

`ifdef INT_SYNC_EN
    logic [NUM_LINES-1:0]   sync1_q, sync2_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= HardwareInterrupt;
            sync2_q <= sync1_q;
        end
    end

    assign line_s = sync2_q;
`else
    assign line_s = HardwareInterrupt;
`endif

    assign rise     = line_s & ~hist_q;
    assign eligible = pending_q & mask_q;

    int_priority_encoder u_prio (
        .eligible (eligible),
        .win_id   (win_id),
        .win_vld  (win_vld)
    );

    always_comb begin
        hist_d  = line_s;
        mask_d  = mask_q;
        gen_d   = gen_q;
        ack_clr = '0;
        state_d = state_q;
        id_d    = id_q;

        if (CfgWrite) begin
            if (CfgSel == CFG_SEL_MASK) begin
                mask_d = CfgData[NUM_LINES-1:0];
            end else begin
                gen_d = CfgData[0];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (gen_q && win_vld && InstrBoundary) begin
                    id_d    = win_id;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (IntAck) begin
                    ack_clr = NUM_LINES'(1) << id_q;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (IntReturn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on the acked line re-arms it: set dominates clear.
        pending_d = (pending_q & ~ack_clr) | rise;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            pending_q <= '0;
            mask_q    <= RESET_MASK;
            gen_q     <= 1'b0;
            hist_q    <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gen_q     <= gen_d;
            hist_q    <= hist_d;
        end
    end

    assign IntRequest   = (state_q == REQUEST);
    assign Busy         = (state_q == SERVICE);
    assign IntId        = id_q;
    assign IntVector    = VECTOR_BASE + (16'(id_q) << VECTOR_SHIFT);
    assign Pending      = pending_q;
    assign Mask         = mask_q;
    assign GlobalEnable = gen_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: expected grants are queued when lines
// are driven and popped when IntRequest appears.
module tb_interrupt_arbiter;

`ifdef INT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] vec;
    } grant_t;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  HardwareInterrupt;
    logic        InstrBoundary;
    logic        IntAck;
    logic        IntReturn;
    logic        CfgWrite;
    logic        CfgSel;
    logic [7:0]  CfgData;
    logic        IntRequest;
    logic [2:0]  IntId;
    logic [15:0] IntVector;
    logic        Busy;
    logic [7:0]  Pending;
    logic [7:0]  Mask;
    logic        GlobalEnable;

    int     checks = 0;
    int     errors = 0;
    grant_t exp_q[$];

    interrupt_arbiter dut (
        .CLK               (CLK),
        .Reset             (Reset),
        .HardwareInterrupt (HardwareInterrupt),
        .InstrBoundary     (InstrBoundary),
        .IntAck            (IntAck),
        .IntReturn         (IntReturn),
        .CfgWrite          (CfgWrite),
        .CfgSel            (CfgSel),
        .CfgData           (CfgData),
        .IntRequest        (IntRequest),
        .IntId             (IntId),
        .IntVector         (IntVector),
        .Busy              (Busy),
        .Pending           (Pending),
        .Mask              (Mask),
        .GlobalEnable      (GlobalEnable)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_grant(input logic [2:0] id, input logic [15:0] vec);
        grant_t g;
        g.id  = id;
        g.vec = vec;
        exp_q.push_back(g);
    endtask

    // Bounded wait for IntRequest, then compare against the oldest queued grant.
    task automatic wait_req(input string tag, input int max_cycles);
        grant_t g;
        for (int i = 0; i < max_cycles; i++) begin
            if (IntRequest) break;
            tick();
        end
        chk({tag, "_req"}, 32'(IntRequest), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            g = exp_q.pop_front();
            chk({tag, "_id"}, 32'(IntId), 32'(g.id));
            chk({tag, "_vec"}, 32'(IntVector), 32'(g.vec));
        end
    endtask

    task automatic cfg(input logic sel, input logic [7:0] data);
        CfgWrite = 1'b1;
        CfgSel   = sel;
        CfgData  = data;
        tick();
        CfgWrite = 1'b0;
    endtask

    task automatic ack();
        IntAck = 1'b1;
        tick();
        IntAck = 1'b0;
    endtask

    task automatic ret();
        IntReturn = 1'b1;
        tick();
        IntReturn = 1'b0;
    endtask

    initial begin
        Reset             = 1'b1;
        HardwareInterrupt = 8'h00;
        InstrBoundary     = 1'b0;
        IntAck            = 1'b0;
        IntReturn         = 1'b0;
        CfgWrite          = 1'b0;
        CfgSel            = 1'b0;
        CfgData           = 8'h00;
        tick();
        tick();
        chk("rst_req", 32'(IntRequest), 32'd0);
        chk("rst_id", 32'(IntId), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_pending", 32'(Pending), 32'h00);
        chk("rst_mask", 32'(Mask), 32'hFF);
        chk("rst_gen", 32'(GlobalEnable), 32'd0);
        Reset = 1'b0;
        tick();

        cfg(1'b1, 8'h01);
        chk("gen_set", 32'(GlobalEnable), 32'd1);
        InstrBoundary = 1'b1;

        // Line 7: pending after first edge, request after the second.
        HardwareInterrupt = 8'h80;
        push_grant(3'd7, 16'h0170);
        repeat (SYNC_LAT) tick();
        tick();
        chk("l7_pending", 32'(Pending), 32'h80);
        chk("l7_req_early", 32'(IntRequest), 32'd0);
        tick();
        wait_req("l7", 1);
        HardwareInterrupt = 8'h00;
        ack();
        chk("l7_busy", 32'(Busy), 32'd1);
        chk("l7_req_off", 32'(IntRequest), 32'd0);
        chk("l7_pend_clr", 32'(Pending), 32'h00);
        ret();
        chk("l7_idle", 32'(Busy), 32'd0);

        // Lines 5 and 2 together: 5 first, then 2.
        HardwareInterrupt = 8'h24;
        push_grant(3'd5, 16'h0150);
        push_grant(3'd2, 16'h0120);
        wait_req("l5", 8);
        ack();
        chk("l5_pend_left", 32'(Pending), 32'h04);
        ret();
        wait_req("l2", 8);
        ack();
        ret();
        chk("l2_pend_end", 32'(Pending), 32'h00);
        HardwareInterrupt = 8'h00;
        tick();

        // Masked line latches but does not request until unmasked.
        cfg(1'b0, 8'hDF);
        chk("mask_df", 32'(Mask), 32'hDF);
        HardwareInterrupt = 8'h20;
        repeat (SYNC_LAT + 3) tick();
        chk("masked_pend", 32'(Pending), 32'h20);
        chk("masked_noreq", 32'(IntRequest), 32'd0);
        cfg(1'b0, 8'hFF);
        push_grant(3'd5, 16'h0150);
        wait_req("unmask", 6);
        ack();
        HardwareInterrupt = 8'h00;

        // Edge during SERVICE accumulates; re-request right after return.
        tick();
        HardwareInterrupt = 8'h08;
        repeat (SYNC_LAT + 2) tick();
        chk("svc_busy", 32'(Busy), 32'd1);
        chk("svc_noreq", 32'(IntRequest), 32'd0);
        chk("svc_pend", 32'(Pending), 32'h08);
        push_grant(3'd3, 16'h0130);
        ret();
        chk("ret_idle_req", 32'(IntRequest), 32'd0);
        tick();
        wait_req("l3", 1);
        ack();
        ret();
        HardwareInterrupt = 8'h00;
        tick();

        // Line 4 re-rises in its own IntAck cycle: set wins.
        HardwareInterrupt = 8'h10;
        push_grant(3'd4, 16'h0140);
        wait_req("l4", 8);
        HardwareInterrupt = 8'h00;
        repeat (SYNC_LAT + 1) tick();
        HardwareInterrupt = 8'h10;
        repeat (SYNC_LAT) tick();
        ack();
        chk("l4_busy", 32'(Busy), 32'd1);
        chk("l4_pend_kept", 32'(Pending), 32'h10);
        push_grant(3'd4, 16'h0140);
        ret();
        wait_req("l4_again", 4);

        // Config writes during REQUEST do not withdraw the committed winner.
        cfg(1'b0, 8'h3C);
        chk("commit_req", 32'(IntRequest), 32'd1);
        chk("commit_id", 32'(IntId), 32'd4);
        chk("commit_mask", 32'(Mask), 32'h3C);

        // Async reset mid-request.
        Reset = 1'b1;
        #1;
        chk("arst_req", 32'(IntRequest), 32'd0);
        chk("arst_pend", 32'(Pending), 32'h00);
        chk("arst_mask", 32'(Mask), 32'hFF);
        chk("arst_gen", 32'(GlobalEnable), 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_id", 32'(IntId), 32'd0);
        tick();
        Reset = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
